// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS core: tracks E/M/W producers, raises stall,
// drives forwarding selects and keeps a saturating stall-cycle counter.
module hazard_sched #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D_valid,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [REG_AW-1:0] D_A3,
  input  logic              D_RegWrite,
  input  logic [1:0]        Tuse_rs,
  input  logic [1:0]        Tuse_rt,
  input  logic [1:0]        D_Tnew,
  input  logic              ext_stall,
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic              fwd_rt_M,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef logic [REG_AW-1:0] reg_t;

  logic       e_vld, e_we;
  reg_t       e_a3, e_rs, e_rt;
  logic [1:0] e_tnew;
  logic       m_vld, m_we;
  reg_t       m_a3, m_rt;
  logic [1:0] m_tnew;
  logic       w_vld, w_we;
  reg_t       w_a3;
  logic       hazard;
  logic       issue;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $0 is never a live destination, so it can neither stall nor forward
  function automatic logic live(input logic vld, input logic we, input reg_t a3, input reg_t r);
    return vld & we & (a3 == r) & (r != '0);
  endfunction

  function automatic logic need_stall(input reg_t r, input logic [1:0] tuse);
    return (tuse != 2'd3) &
           ((live(e_vld, e_we, e_a3, r) & (tuse < e_tnew)) |
            (live(m_vld, m_we, m_a3, r) & (tuse < m_tnew)));
  endfunction

  function automatic logic [1:0] sel_d(input reg_t r);
    if (live(e_vld, e_we, e_a3, r) && e_tnew == 2'd0)      return 2'b11;
    else if (live(m_vld, m_we, m_a3, r) && m_tnew == 2'd0) return 2'b10;
    else if (live(w_vld, w_we, w_a3, r))                   return 2'b01;
    else                                                   return 2'b00;
  endfunction

  function automatic logic [1:0] sel_e(input reg_t r);
    if (live(m_vld, m_we, m_a3, r) && m_tnew == 2'd0) return 2'b10;
    else if (live(w_vld, w_we, w_a3, r))              return 2'b01;
    else                                              return 2'b00;
  endfunction

  always_comb begin
    hazard   = D_valid & (need_stall(D_rs, Tuse_rs) | need_stall(D_rt, Tuse_rt));
    stall    = hazard | ext_stall;
    issue    = D_valid & ~stall;
    fwd_rs_D = sel_d(D_rs);
    fwd_rt_D = sel_d(D_rt);
    fwd_rs_E = sel_e(e_rs);
    fwd_rt_E = sel_e(e_rt);
    fwd_rt_M = live(w_vld, w_we, w_a3, m_rt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld     <= 1'b0;
      e_we      <= 1'b0;
      e_a3      <= '0;
      e_rs      <= '0;
      e_rt      <= '0;
      e_tnew    <= 2'd0;
      m_vld     <= 1'b0;
      m_we      <= 1'b0;
      m_a3      <= '0;
      m_rt      <= '0;
      m_tnew    <= 2'd0;
      w_vld     <= 1'b0;
      w_we      <= 1'b0;
      w_a3      <= '0;
      stall_cnt <= '0;
    end else begin
      w_vld  <= m_vld;
      w_we   <= m_we;
      w_a3   <= m_a3;
      m_vld  <= e_vld;
      m_we   <= e_we;
      m_a3   <= e_a3;
      m_rt   <= e_rt;
      m_tnew <= dec_sat(e_tnew);
      // a bubble clears every field so it can never match as consumer or producer
      e_vld  <= issue;
      e_we   <= issue & D_RegWrite;
      e_a3   <= issue ? D_A3 : '0;
      e_rs   <= issue ? D_rs : '0;
      e_rt   <= issue ? D_rt : '0;
      e_tnew <= issue ? dec_sat(D_Tnew) : 2'd0;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed pipeline scenarios plus randomized traffic checked
// against an instruction-age model of the E/M/W pipeline.
module tb_hazard_sched;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          D_valid, D_RegWrite, ext_stall;
  logic [4:0]    D_rs, D_rt, D_A3;
  logic [1:0]    Tuse_rs, Tuse_rt, D_Tnew;
  logic          stall, fwd_rt_M;
  logic [1:0]    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_sched #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt), .D_A3(D_A3),
    .D_RegWrite(D_RegWrite), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .D_Tnew(D_Tnew),
    .ext_stall(ext_stall), .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: index k = instruction that entered E k cycles ago (0=E, 1=M, 2=W)
  int h_vld[3], h_we[3], h_a3[3], h_rs[3], h_rt[3], h_tn[3];
  int mcnt;
  logic       exp_stall, exp_frtM;
  logic [1:0] exp_frsD, exp_frtD, exp_frsE, exp_frtE;

  function automatic int rem(input int k);
    return (h_tn[k] > k + 1) ? h_tn[k] - k - 1 : 0;
  endfunction

  function automatic bit live(input int k, input int r);
    return h_vld[k] != 0 && h_we[k] != 0 && h_a3[k] == r && r != 0;
  endfunction

  function automatic int fwd_from(input int r, input int first);
    for (int k = first; k < 3; k++)
      if (live(k, r) && rem(k) == 0) return 3 - k;
    return 0;
  endfunction

  function automatic bit needs(input int r, input int tuse);
    if (tuse == 3) return 0;
    for (int k = 0; k < 3; k++)
      if (live(k, r) && tuse < rem(k)) return 1;
    return 0;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      h_vld[k] = 0; h_we[k] = 0; h_a3[k] = 0; h_rs[k] = 0; h_rt[k] = 0; h_tn[k] = 0;
    end
    mcnt = 0;
  endtask

  task automatic model_eval();
    exp_stall = ext_stall | (D_valid & (needs(int'(D_rs), int'(Tuse_rs)) |
                                        needs(int'(D_rt), int'(Tuse_rt))));
    exp_frsD = 2'(fwd_from(int'(D_rs), 0));
    exp_frtD = 2'(fwd_from(int'(D_rt), 0));
    exp_frsE = 2'(fwd_from(h_rs[0], 1));
    exp_frtE = 2'(fwd_from(h_rt[0], 1));
    exp_frtM = 1'(fwd_from(h_rt[1], 2));
  endtask

  // Commit the current D-stage inputs to the model, then advance one clock
  task automatic step();
    model_eval();
    if (exp_stall && mcnt < CMAX) mcnt++;
    for (int k = 2; k > 0; k--) begin
      h_vld[k] = h_vld[k-1]; h_we[k] = h_we[k-1]; h_a3[k] = h_a3[k-1];
      h_rs[k] = h_rs[k-1]; h_rt[k] = h_rt[k-1]; h_tn[k] = h_tn[k-1];
    end
    if (exp_stall || !D_valid) begin
      h_vld[0] = 0; h_we[0] = 0; h_a3[0] = 0; h_rs[0] = 0; h_rt[0] = 0; h_tn[0] = 0;
    end else begin
      h_vld[0] = 1; h_we[0] = int'(D_RegWrite); h_a3[0] = int'(D_A3);
      h_rs[0] = int'(D_rs); h_rt[0] = int'(D_rt); h_tn[0] = int'(D_Tnew);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input int a3, input logic we,
                       input int tur, input int tut, input int tn, input logic ext);
    D_valid = v; D_rs = 5'(rs); D_rt = 5'(rt); D_A3 = 5'(a3); D_RegWrite = we;
    Tuse_rs = 2'(tur); Tuse_rt = 2'(tut); D_Tnew = 2'(tn); ext_stall = ext;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 3, 3, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0, 3, 3, 0, 1'b1);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL rst_ext_pass stall=%b exp=1", stall); end
    do_reset();
    checks++;
    if (stall !== 1'b0 || stall_cnt !== '0) begin
      failures++; $display("FAIL reset_idle stall=%b cnt=%0d exp 0/0", stall, stall_cnt);
    end
    checks++;
    if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M} !== 9'b0) begin
      failures++;
      $display("FAIL reset_fwd got=%b exp=0", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M});
    end
    // lw $8 then beq $8: one stall counted, then reset mid-stall
    drive(1'b1, 29, 8, 8, 1'b1, 1, 3, 3, 1'b0); step();
    drive(1'b1, 8, 0, 0, 1'b0, 0, 0, 0, 1'b0); step();
    checks++;
    if (stall_cnt !== CW'(1)) begin failures++; $display("FAIL pre_rst_cnt cnt=%0d exp=1", stall_cnt); end
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    checks++;
    if (stall !== 1'b0 || stall_cnt !== '0) begin
      failures++; $display("FAIL midrun_reset stall=%b cnt=%0d exp 0/0", stall, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw_branch();
    do_reset();
    drive(1'b1, 29, 8, 8, 1'b1, 1, 3, 3, 1'b0); step();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 8, 0, 0, 1'b0, 0, 0, 0, 1'b0);
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL lw_beq_stall%0d stall=%b exp=1", c, stall); end
      step();
    end
    drive(1'b1, 8, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'b01 || stall_cnt !== CW'(2)) begin
      failures++;
      $display("FAIL lw_beq_release stall=%b fwd=%b cnt=%0d exp 0/01/2", stall, fwd_rs_D, stall_cnt);
    end
    step();
  endtask

  task automatic test_lw_alu();
    do_reset();
    drive(1'b1, 29, 8, 8, 1'b1, 1, 3, 3, 1'b0); step();
    drive(1'b1, 8, 0, 9, 1'b1, 1, 1, 2, 1'b0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lw_add_stall stall=%b exp=1", stall); end
    step();
    drive(1'b1, 8, 0, 9, 1'b1, 1, 1, 2, 1'b0);
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'b00) begin
      failures++; $display("FAIL lw_add_issue stall=%b fwdD=%b exp 0/00", stall, fwd_rs_D);
    end
    step();
    idle();
    checks++;
    if (fwd_rs_E !== 2'b01 || fwd_rt_E !== 2'b00) begin
      failures++; $display("FAIL lw_add_fwdE rs=%b rt=%b exp 01/00", fwd_rs_E, fwd_rt_E);
    end
    step();
  endtask

  task automatic test_alu_store();
    do_reset();
    drive(1'b1, 1, 2, 8, 1'b1, 1, 1, 2, 1'b0); step();
    drive(1'b1, 29, 8, 0, 1'b0, 1, 2, 0, 1'b0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL add_sw_nostall stall=%b exp=0", stall); end
    step();
    idle();
    checks++;
    if (fwd_rt_E !== 2'b10) begin failures++; $display("FAIL sw_fwd_rt_E got=%b exp=10", fwd_rt_E); end
    step();
    idle();
    checks++;
    if (fwd_rt_M !== 1'b1) begin failures++; $display("FAIL sw_fwd_rt_M got=%b exp=1", fwd_rt_M); end
    step();
  endtask

  task automatic test_jal_zero();
    do_reset();
    drive(1'b1, 0, 0, 31, 1'b1, 3, 3, 0, 1'b0); step();
    drive(1'b1, 31, 0, 0, 1'b0, 0, 3, 0, 1'b0);
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'b11) begin
      failures++; $display("FAIL jal_jr stall=%b fwd=%b exp 0/11", stall, fwd_rs_D);
    end
    step();
    drive(1'b1, 29, 0, 0, 1'b1, 1, 3, 3, 1'b0); step();
    drive(1'b1, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'b00 || fwd_rt_D !== 2'b00) begin
      failures++; $display("FAIL zero_reg stall=%b fwd=%b%b exp 0/0000", stall, fwd_rs_D, fwd_rt_D);
    end
    step();
  endtask

  task automatic test_ext_stall();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1, 2, 8, 1'b1, 1, 1, 2, 1'b1);
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL ext_stall%0d stall=%b exp=1", c, stall); end
      step();
    end
    // if the held add had leaked into E, this reader of $8 would stall
    drive(1'b1, 8, 0, 0, 1'b0, 0, 3, 0, 1'b0);
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'b00 || stall_cnt !== CW'(4)) begin
      failures++;
      $display("FAIL ext_bubbles stall=%b fwd=%b cnt=%0d exp 0/00/4", stall, fwd_rs_D, stall_cnt);
    end
    step();
    drive(1'b1, 29, 8, 8, 1'b1, 1, 3, 3, 1'b1);
    for (int c = 0; c < CMAX + 10; c++) step();
    checks++;
    if (stall_cnt !== CW'(CMAX)) begin
      failures++; $display("FAIL cnt_saturate cnt=%0d exp=%0d", stall_cnt, CMAX);
    end
    idle();
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      model_eval();
      checks++;
      if (stall !== exp_stall || fwd_rs_D !== exp_frsD || fwd_rt_D !== exp_frtD ||
          fwd_rs_E !== exp_frsE || fwd_rt_E !== exp_frtE || fwd_rt_M !== exp_frtM ||
          stall_cnt !== CW'(mcnt)) begin
        failures++;
        $display("FAIL random[%0d] got s=%b %b %b %b %b %b c=%0d exp s=%b %b %b %b %b %b c=%0d", i,
                 stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt,
                 exp_stall, exp_frsD, exp_frtD, exp_frsE, exp_frtE, exp_frtM, mcnt);
      end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b1;
    mreset();
    idle();
    test_reset();
    test_lw_branch();
    test_lw_alu();
    test_alu_store();
    test_jal_zero();
    test_ext_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
